last_kpg_cell: RTL and testbench

- Registered kill/propagate/generate (KPG) status encoder for the recursive-doubling adder in the ALU.
- Takes two WIDTH-bit operands and emits one 2-bit KPG code per bit position, packed into a 2*WIDTH-bit vector.
- Feeds the prefix-combine stages of the recursive adder. Optionally computes the resolved carries itself.

---
 rtl/last_kpg_pkg.sv | 15 +
 rtl/last_kpg_combine.sv | 12 +
 rtl/last_kpg_cell.sv | 91 +++++++++
 tb/tb_last_kpg_cell.sv | 125 ++++++++++++
 4 files changed

// File: rtl/last_kpg_pkg.sv
// Shared KPG types, status codes and the bit encoder for the recursive-doubling adder.
package last_kpg_pkg;

   typedef logic [1:0] kpg_t;

   localparam kpg_t KPG_KILL = 2'b00;
   localparam kpg_t KPG_PROP = 2'b10;
   localparam kpg_t KPG_GEN  = 2'b11;

   // {a|b, a&b} yields kill/propagate/generate; 2'b01 is unreachable.
   function automatic kpg_t kpg_encode(input logic a, input logic b);
      return {a | b, a & b};
   endfunction

endpackage

// File: rtl/last_kpg_combine.sv
// KPG combine operator x∘y: a propagating upper group passes the lower status through.
module last_kpg_combine
   import last_kpg_pkg::*;
(
   input  kpg_t i_hi,
   input  kpg_t i_lo,
   output kpg_t o_res
);

   assign o_res = (i_hi == KPG_PROP) ? i_lo : i_hi;

endmodule

// File: rtl/last_kpg_cell.sv
// Registered KPG encoder; with LAST_PREFIX_EN defined it also resolves carries
// through a log2(WIDTH)-stage recursive-doubling prefix network.
module last_kpg_cell
   import last_kpg_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid
`ifdef LAST_PREFIX_EN
   ,
   output logic [WIDTH-1:0]     carry
`endif
);

   logic [2*WIDTH-1:0] w_enc;
   logic [2*WIDTH-1:0] r_out;
   logic               r_valid;

   always_comb begin
      w_enc = '0;
      for (int i = 0; i < WIDTH; i++)
         w_enc[2*i +: 2] = kpg_encode(a[i], b[i]);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid)
            r_out <= w_enc;
      end
   end

   assign out       = r_out;
   assign out_valid = r_valid;

`ifdef LAST_PREFIX_EN
   localparam int STAGES = $clog2(WIDTH);

   logic [STAGES:0][WIDTH-1:0][1:0] w_lvl;
   logic [WIDTH-1:0]                w_carry;
   logic [WIDTH-1:0]                r_carry;

   assign w_lvl[0] = w_enc;

   // Positions below bit 0 behave as kill: the carry-in is zero.
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= (1 << s)) begin : g_pair
            last_kpg_combine u_comb (
               .i_hi  (w_lvl[s][i]),
               .i_lo  (w_lvl[s][i - (1 << s)]),
               .o_res (w_lvl[s+1][i])
            );
         end else begin : g_edge
            last_kpg_combine u_comb (
               .i_hi  (w_lvl[s][i]),
               .i_lo  (KPG_KILL),
               .o_res (w_lvl[s+1][i])
            );
         end
      end
   end

   always_comb begin
      w_carry = '0;
      for (int i = 0; i < WIDTH; i++)
         w_carry[i] = (w_lvl[STAGES][i] == KPG_GEN);
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_carry <= '0;
      else if (in_valid)
         r_carry <= w_carry;
   end

   assign carry = r_carry;
`endif

endmodule

// File: tb/tb_last_kpg_cell.sv
// Self-checking bench for last_kpg_cell; carry checks are active when LAST_PREFIX_EN is defined.
module tb_last_kpg_cell;

   localparam int W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [W-1:0]     a = '0;
   logic [W-1:0]     b = '0;
   logic [2*W-1:0]   out;
   logic             out_valid;
`ifdef LAST_PREFIX_EN
   logic [W-1:0]     carry;
`endif

   int n_vec = 0;
   int n_bad = 0;

   logic [2*W-1:0] exp_out   = '0;
   logic           exp_valid = 1'b0;
   logic [W-1:0]   exp_carry = '0;

   last_kpg_cell #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out       (out),
      .out_valid (out_valid)
`ifdef LAST_PREFIX_EN
      ,
      .carry     (carry)
`endif
   );

   always #5 clk = ~clk;

   // Reference: per-bit classification and carries from true binary addition.
   function automatic logic [2*W-1:0] ref_kpg(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) begin
         if (x[i] && y[i])      r[2*i +: 2] = 2'b11;
         else if (x[i] != y[i]) r[2*i +: 2] = 2'b10;
         else                   r[2*i +: 2] = 2'b00;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] ref_carry(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] c;
      logic [63:0]  m, s;
      for (int i = 0; i < W; i++) begin
         m    = (64'd1 << (i + 1)) - 64'd1;
         s    = (64'(x) & m) + (64'(y) & m);
         c[i] = s[i+1];
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Apply one cycle of inputs, advance the model, then compare just after the edge.
   task automatic step(input logic r, input logic v, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input string tag);
      rst = r; in_valid = v; a = va; b = vb;
      @(posedge clk);
      if (r) begin
         exp_out = '0; exp_valid = 1'b0; exp_carry = '0;
      end else begin
         exp_valid = v;
         if (v) begin
            exp_out   = ref_kpg(va, vb);
            exp_carry = ref_carry(va, vb);
         end
      end
      #1;
      check({tag, ".out"},   64'(out),       64'(exp_out));
      check({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
`ifdef LAST_PREFIX_EN
      check({tag, ".carry"}, 64'(carry),     64'(exp_carry));
`endif
   endtask

   initial begin
      @(negedge clk);

      step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, "reset");
      check("reset.zero", 64'(out), 64'h0);
      step(1'b0, 1'b1, 16'h0000, 16'h0000, "first_kill");
      step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, "all_gen");
      check("all_gen.const", 64'(out), 64'hFFFF_FFFF);
      step(1'b0, 1'b1, 16'h00FF, 16'hFF00, "all_prop");
      check("all_prop.const", 64'(out), 64'hAAAA_AAAA);
      step(1'b0, 1'b1, 16'h0001, 16'h0001, "iso_gen");
      check("iso_gen.const", 64'(out), 64'h0000_0003);
      step(1'b0, 1'b1, 16'h0001, 16'hFFFF, "gen_prop");
      check("gen_prop.const", 64'(out), 64'hAAAA_AAAB);
`ifdef LAST_PREFIX_EN
      check("gen_prop.carry_const", 64'(carry), 64'hFFFF);
`endif

      step(1'b0, 1'b1, 16'h1234, 16'h00F0, "hold_load");
      for (int k = 0; k < 3; k++)
         step(1'b0, 1'b0, W'($urandom), W'($urandom), "hold");

      for (int k = 0; k < 1000; k++) begin
         if (k == 400 || k == 731)
            step(1'b1, 1'b1, W'($urandom), W'($urandom), "rand_rst");
         else
            step(1'b0, ($urandom_range(0, 7) != 0), W'($urandom), W'($urandom), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
